paddle_stream_sequencer: RTL and testbench
==========================================

Name: paddle_stream_sequencer

Overview:
- Frame/pixel sequencer for the paddle-localization datapath.
- Consumes the raw pixel-valid stream with its start-of-frame marker and produces the shared timing signals: row/col coordinates, image-valid qualifier, frame toggle code, window-centre valid and coordinates.
- Sequences frame capture under start/stop control, which lets the colour-mask, denoise, Sobel and merge stages run one frame or continuously.
- Sits between the video input and the YUV/mask/window pipeline.

Parameters:
- LINE_WIDTH, 640, active pixels per line.
- FRAME_HEIGHT, 480, active lines per frame.
- WIN_SIZE, 5, odd sliding-window size used for window-centre tracking.
- CNT_WIDTH, 13, width of the row/col counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- start  in  1  pulse; arm capture.
- stop  in  1  pulse; stop after the current frame.
- continuous  in  1  1 = re-arm automatically after each frame.
- in_valid  in  1  pixel present this cycle.
- in_sof  in  1  qualifies the in_valid pixel as pixel (0,0).
- img_in_valid  out  1  registered; the accepted pixel is in the active frame.
- row  out  CNT_WIDTH  registered row of the accepted pixel.
- col  out  CNT_WIDTH  registered column of the accepted pixel.
- frame_code  out  1  toggles on every accepted SOF.
- win_valid  out  1  a full WIN_SIZE window exists around (win_row, win_col).
- win_row  out  CNT_WIDTH  window-centre row.
- win_col  out  CNT_WIDTH  window-centre column.
- frame_done  out  1  one-cycle pulse after the last pixel.
- busy  out  1  state is not IDLE.
- err_sync  out  1  sticky; SOF arrived mid-frame.

Behaviour:
- Reset: all outputs 0. State goes to IDLE. Internal counters and stop_pending clear.
- Latency: every output is registered 1 cycle after the in_valid it describes. The datapath delays pixel data by 1 cycle to align.
- States:
  - IDLE: start=1 with stop=0 moves to ARMED and clears err_sync. stop in IDLE is ignored. start and stop in the same cycle keep IDLE.
  - ARMED: in_valid without in_sof is ignored (img_in_valid=0). in_valid with in_sof accepts the pixel as (0,0), toggles frame_code, and moves to ACTIVE. stop moves to IDLE immediately.
  - ACTIVE:
    - Each in_valid is accepted and col increments.
    - At col=LINE_WIDTH-1, col wraps to 0 and row increments.
    - Cycles with in_valid=0 hold the counters and drive img_in_valid=0, win_valid=0.
    - stop sets stop_pending. start is ignored while busy.
- Frame end: the pixel (FRAME_HEIGHT-1, LINE_WIDTH-1) is accepted normally, and frame_done pulses together with its registered outputs. Next state is ARMED if continuous=1 and stop_pending=0; otherwise IDLE, clearing stop_pending.
- Mid-frame SOF: in_valid&in_sof in ACTIVE at a position other than (0,0) does the following:
  - err_sync is set (sticky until reset or an accepted start).
  - The counters restart, so that pixel is (0,0).
  - frame_code toggles.
  - No frame_done is issued for the aborted frame.
- Window tracking, with H=(WIN_SIZE-1)/2:
  - win_valid = img_in_valid & row>=WIN_SIZE-1 & col>=WIN_SIZE-1, computed from the accepted pixel's coordinates.
  - win_row = row-H and win_col = col-H, both valid only while win_valid=1; otherwise hold the last value.
  - Border pixels never produce win_valid.
- Reset mid-frame: immediate return to IDLE with every output 0. The next frame needs start followed by SOF.
- Arithmetic: counters are unsigned CNT_WIDTH bits and never exceed LINE_WIDTH-1 / FRAME_HEIGHT-1. Elaboration asserts LINE_WIDTH and FRAME_HEIGHT fit in CNT_WIDTH, WIN_SIZE is odd, and WIN_SIZE <= min(LINE_WIDTH, FRAME_HEIGHT).

Decomposition:
- Shared package paddle_pkg:
  - state enum seq_state_t {IDLE, ARMED, ACTIVE};
  - CNT_WIDTH default;
  - default LINE_WIDTH/FRAME_HEIGHT constants reused by the window and Sobel instances.
- Sub-module pixel_coord_counter: row/col counter with inc, restart and last-pixel flag outputs. The sequencer FSM, window logic and error logic stay in the top.

Test Plan (LINE_WIDTH=8, FRAME_HEIGHT=4, WIN_SIZE=3 unless stated):
- Single frame: start, then 32 consecutive in_valid with in_sof on the first -> img_in_valid for 32 cycles, coordinates (0,0)..(3,7), frame_code 0->1, frame_done on the cycle reporting (3,7), busy drops to 0 the following cycle.
- Window: same frame -> win_valid on exactly 12 pixels (rows 2-3, cols 2-7); first pulse reports win_row=1, win_col=1, last reports win_row=2, win_col=6.
- Continuous with gaps: continuous=1, two frames with in_valid deasserted every 3rd cycle -> counters hold across gaps, two frame_done pulses, frame_code returns to 0, state is ARMED after frame 2.
- Stop mid-frame: stop at pixel (1,4) with continuous=1 -> frame completes, frame_done pulses, then IDLE; a following SOF is ignored (img_in_valid=0).
- Mid-frame SOF: in_sof at pixel (2,3) -> err_sync=1, that pixel reported as (0,0), frame_code toggles, no frame_done until 32 further pixels; start after the frame clears err_sync.
- Reset mid-frame: reset at pixel (1,1) -> next cycle all outputs 0, busy=0; in_valid+in_sof without start produces no img_in_valid.

Source files
------------

// File: rtl/paddle_pkg.sv
// paddle_pkg: shared sequencer state type and default geometry for the paddle pipeline
package paddle_pkg;
  localparam int DEF_CNT_WIDTH = 13;
  localparam int DEF_LINE_WIDTH = 640;
  localparam int DEF_FRAME_HEIGHT = 480;
  localparam int DEF_WIN_SIZE = 5;
  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} seq_state_t;
endpackage

// File: rtl/pixel_coord_counter.sv
// pixel_coord_counter: row/col position of the current pixel with restart and last-pixel flag
module pixel_coord_counter import paddle_pkg::*; #(
  parameter int LINE_WIDTH = DEF_LINE_WIDTH,
  parameter int FRAME_HEIGHT = DEF_FRAME_HEIGHT,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 restart,
  output logic [CNT_WIDTH-1:0] pix_row,
  output logic [CNT_WIDTH-1:0] pix_col,
  output logic                 last
);
  localparam logic [CNT_WIDTH-1:0] LAST_COL = CNT_WIDTH'(LINE_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_ROW = CNT_WIDTH'(FRAME_HEIGHT - 1);
  logic [CNT_WIDTH-1:0] row_q, row_d, col_q, col_d;
  logic col_wrap;
  always_comb begin
    pix_row = restart ? '0 : row_q;
    pix_col = restart ? '0 : col_q;
    col_wrap = pix_col == LAST_COL;
    last = col_wrap && pix_row == LAST_ROW;
    col_d = inc ? (col_wrap ? '0 : pix_col + CNT_WIDTH'(1)) : pix_col;
    row_d = (inc && col_wrap) ? (last ? '0 : pix_row + CNT_WIDTH'(1)) : pix_row;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end
endmodule

// File: rtl/paddle_stream_sequencer.sv
// paddle_stream_sequencer: frame capture sequencer producing pixel coordinates, window-centre and frame timing
module paddle_stream_sequencer import paddle_pkg::*; #(
  parameter int LINE_WIDTH = DEF_LINE_WIDTH,
  parameter int FRAME_HEIGHT = DEF_FRAME_HEIGHT,
  parameter int WIN_SIZE = DEF_WIN_SIZE,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 continuous,
  input  logic                 in_valid,
  input  logic                 in_sof,
  output logic                 img_in_valid,
  output logic [CNT_WIDTH-1:0] row,
  output logic [CNT_WIDTH-1:0] col,
  output logic                 frame_code,
  output logic                 win_valid,
  output logic [CNT_WIDTH-1:0] win_row,
  output logic [CNT_WIDTH-1:0] win_col,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 err_sync
);
  localparam logic [CNT_WIDTH-1:0] WIN_MIN = CNT_WIDTH'(WIN_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0] WIN_H = CNT_WIDTH'((WIN_SIZE - 1) / 2);
  if (((LINE_WIDTH - 1) >> CNT_WIDTH) != 0 || ((FRAME_HEIGHT - 1) >> CNT_WIDTH) != 0 ||
      WIN_SIZE % 2 == 0 || WIN_SIZE > LINE_WIDTH || WIN_SIZE > FRAME_HEIGHT) begin : g_bad_params
    $error("paddle_stream_sequencer: invalid geometry parameters");
  end
  seq_state_t state_q, state_d;
  logic stop_pend_q, stop_pend_d, err_q, err_d, fc_q, fc_d;
  logic img_q, img_d, win_q, win_d, done_q, done_d, busy_q, busy_d;
  logic [CNT_WIDTH-1:0] row_q, row_d, col_q, col_d, wrow_q, wrow_d, wcol_q, wcol_d;
  logic [CNT_WIDTH-1:0] pix_row, pix_col;
  logic accept, sof_acc, last, done, stop_eff;
  pixel_coord_counter #(
    .LINE_WIDTH(LINE_WIDTH),
    .FRAME_HEIGHT(FRAME_HEIGHT),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_cnt (
    .clk(clk),
    .reset(reset),
    .inc(accept),
    .restart(sof_acc),
    .pix_row(pix_row),
    .pix_col(pix_col),
    .last(last)
  );
  always_comb begin
    accept = in_valid && (state_q == ACTIVE || (state_q == ARMED && in_sof && !stop));
    sof_acc = accept && in_sof;
    done = accept && last;
    stop_eff = stop_pend_q || (state_q == ACTIVE && stop);
    state_d = state_q;
    err_d = err_q;
    stop_pend_d = (state_q == ACTIVE && stop) ? 1'b1 : stop_pend_q;
    if (state_q == IDLE && start && !stop) begin
      state_d = ARMED;
      err_d = 1'b0;
    end
    if (state_q == ARMED && stop) state_d = IDLE;
    if (sof_acc) begin
      state_d = ACTIVE;
      err_d = err_q || state_q == ACTIVE;
    end
    if (done) begin
      state_d = (continuous && !stop_eff) ? ARMED : IDLE;
      stop_pend_d = 1'b0;
    end
    fc_d = fc_q ^ sof_acc;
    img_d = accept;
    row_d = accept ? pix_row : row_q;
    col_d = accept ? pix_col : col_q;
    win_d = accept && pix_row >= WIN_MIN && pix_col >= WIN_MIN;
    wrow_d = win_d ? pix_row - WIN_H : wrow_q;
    wcol_d = win_d ? pix_col - WIN_H : wcol_q;
    done_d = done;
    busy_d = state_q != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      stop_pend_q <= 1'b0;
      err_q <= 1'b0;
      fc_q <= 1'b0;
      img_q <= 1'b0;
      win_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      row_q <= '0;
      col_q <= '0;
      wrow_q <= '0;
      wcol_q <= '0;
    end else begin
      state_q <= state_d;
      stop_pend_q <= stop_pend_d;
      err_q <= err_d;
      fc_q <= fc_d;
      img_q <= img_d;
      win_q <= win_d;
      done_q <= done_d;
      busy_q <= busy_d;
      row_q <= row_d;
      col_q <= col_d;
      wrow_q <= wrow_d;
      wcol_q <= wcol_d;
    end
  end
  assign img_in_valid = img_q;
  assign row = row_q;
  assign col = col_q;
  assign frame_code = fc_q;
  assign win_valid = win_q;
  assign win_row = wrow_q;
  assign win_col = wcol_q;
  assign frame_done = done_q;
  assign busy = busy_q;
  assign err_sync = err_q;
endmodule

// File: tb/tb_paddle_stream_sequencer.sv
// tb_paddle_stream_sequencer: randomized and directed checks against a pixel-index reference model
module tb_paddle_stream_sequencer;
  localparam int LW = 8;
  localparam int FH = 4;
  localparam int WS = 3;
  localparam int CW = 13;
  localparam int H = (WS - 1) / 2;
  localparam int NPIX = LW * FH;
  logic clk = 1'b0;
  logic reset = 1'b0, start = 1'b0, stop = 1'b0, continuous = 1'b0, in_valid = 1'b0, in_sof = 1'b0;
  logic img_in_valid, frame_code, win_valid, frame_done, busy, err_sync;
  logic [CW-1:0] row, col, win_row, win_col;
  int compared = 0;
  int mismatched = 0;
  int m_mode, m_p;
  bit m_sp, m_fc, m_err;
  logic e_iv, e_fc, e_wv, e_fd, e_busy, e_err;
  logic [CW-1:0] e_row, e_col, e_wr, e_wc;
  logic [57:0] got, expv;
  always #5 clk = ~clk;
  paddle_stream_sequencer #(
    .LINE_WIDTH(LW),
    .FRAME_HEIGHT(FH),
    .WIN_SIZE(WS),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .stop(stop),
    .continuous(continuous),
    .in_valid(in_valid),
    .in_sof(in_sof),
    .img_in_valid(img_in_valid),
    .row(row),
    .col(col),
    .frame_code(frame_code),
    .win_valid(win_valid),
    .win_row(win_row),
    .win_col(win_col),
    .frame_done(frame_done),
    .busy(busy),
    .err_sync(err_sync)
  );
  assign got = {img_in_valid, row, col, frame_code, win_valid, win_row, win_col, frame_done, busy, err_sync};
  assign expv = {e_iv, e_row, e_col, e_fc, e_wv, e_wr, e_wc, e_fd, e_busy, e_err};
  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    m_mode = 0;
    m_p = 0;
    m_sp = 0;
    m_fc = 0;
    m_err = 0;
    {e_iv, e_row, e_col, e_fc, e_wv, e_wr, e_wc, e_fd, e_busy, e_err} = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  task automatic tick(input bit st, input bit sp, input bit iv, input bit sof);
    bit acc;
    acc = 0;
    start = st;
    stop = sp;
    in_valid = iv;
    in_sof = sof;
    e_busy = m_mode != 0;
    e_iv = 0;
    e_wv = 0;
    e_fd = 0;
    if (m_mode == 0) begin
      if (st && !sp) begin
        m_mode = 1;
        m_err = 0;
      end
    end else if (m_mode == 1) begin
      if (sp) m_mode = 0;
      else if (iv && sof) begin
        acc = 1;
        m_p = 0;
        m_fc = !m_fc;
        m_mode = 2;
      end
    end else begin
      if (sp) m_sp = 1;
      if (iv) begin
        acc = 1;
        if (sof) begin
          m_err = 1;
          m_p = 0;
          m_fc = !m_fc;
        end
      end
    end
    if (acc) begin
      e_iv = 1;
      e_row = CW'(m_p / LW);
      e_col = CW'(m_p % LW);
      e_wv = (m_p / LW) >= WS - 1 && (m_p % LW) >= WS - 1;
      if (e_wv) begin
        e_wr = CW'(m_p / LW - H);
        e_wc = CW'(m_p % LW - H);
      end
      if (m_p == NPIX - 1) begin
        e_fd = 1;
        m_mode = (continuous && !m_sp) ? 1 : 0;
        m_sp = 0;
        m_p = 0;
      end else m_p++;
    end
    e_fc = m_fc;
    e_err = m_err;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    in_valid = 1'b1;
    in_sof = 1'b1;
    do_reset();
    compared++;
    if (got !== expv) begin
      mismatched++;
      $display("FAIL reset_model: got %h exp %h", got, expv);
    end
    compared++;
    if (got !== 58'd0) begin
      mismatched++;
      $display("FAIL reset_zero: got %h exp 0", got);
    end
  endtask
  task automatic test_single_frame();
    int ivc, wvc, fdc;
    bit first;
    logic [CW-1:0] fr, fcl, lr, lc;
    ivc = 0; wvc = 0; fdc = 0; first = 1; fr = '0; fcl = '0; lr = '0; lc = '0;
    continuous = 1'b0;
    tick(1, 0, 0, 0);
    for (int i = 0; i < NPIX; i++) begin
      tick(0, 0, 1, i == 0);
      compared++;
      if (got !== expv) begin
        mismatched++;
        $display("FAIL single_pix%0d: got %h exp %h", i, got, expv);
      end
      if (img_in_valid === 1'b1) ivc++;
      if (win_valid === 1'b1) begin
        if (first) begin
          fr = win_row;
          fcl = win_col;
          first = 0;
        end
        lr = win_row;
        lc = win_col;
        wvc++;
      end
      if (frame_done === 1'b1) begin
        fdc++;
        compared++;
        if (row !== 3 || col !== 7) begin
          mismatched++;
          $display("FAIL single_done_pos: got (%0d,%0d) exp (3,7)", row, col);
        end
      end
    end
    tick(0, 0, 0, 0);
    compared++;
    if (busy !== 1'b0 || got !== expv) begin
      mismatched++;
      $display("FAIL single_busy_drop: got busy %b exp 0", busy);
    end
    compared++;
    if (ivc != 32) begin
      mismatched++;
      $display("FAIL single_iv_count: got %0d exp 32", ivc);
    end
    compared++;
    if (wvc != 12) begin
      mismatched++;
      $display("FAIL single_win_count: got %0d exp 12", wvc);
    end
    compared++;
    if (fr !== 1 || fcl !== 1 || lr !== 2 || lc !== 6) begin
      mismatched++;
      $display("FAIL single_win_pos: got first (%0d,%0d) last (%0d,%0d) exp (1,1) (2,6)", fr, fcl, lr, lc);
    end
    compared++;
    if (fdc != 1 || frame_code !== 1'b1) begin
      mismatched++;
      $display("FAIL single_done_code: got done %0d code %b exp 1 1", fdc, frame_code);
    end
  endtask
  task automatic test_continuous_gaps();
    int sent, fdc;
    logic fc0;
    bit iv;
    sent = 0; fdc = 0; fc0 = frame_code;
    continuous = 1'b1;
    tick(1, 0, 0, 0);
    for (int k = 0; k < 200 && sent < 64; k++) begin
      iv = (k % 3) != 2;
      tick(0, 0, iv, iv && sent % NPIX == 0);
      compared++;
      if (got !== expv) begin
        mismatched++;
        $display("FAIL cont_cycle%0d: got %h exp %h", k, got, expv);
      end
      if (iv) sent++;
      if (frame_done === 1'b1) fdc++;
    end
    compared++;
    if (fdc != 2 || frame_code !== fc0) begin
      mismatched++;
      $display("FAIL cont_done_code: got done %0d code %b exp 2 %b", fdc, frame_code, fc0);
    end
    tick(0, 0, 0, 0);
    compared++;
    if (busy !== 1'b1 || got !== expv) begin
      mismatched++;
      $display("FAIL cont_armed: got busy %b exp 1", busy);
    end
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    compared++;
    if (busy !== 1'b0 || got !== expv) begin
      mismatched++;
      $display("FAIL cont_stop_idle: got busy %b exp 0", busy);
    end
  endtask
  task automatic test_stop_mid();
    int fdc;
    fdc = 0;
    continuous = 1'b1;
    tick(1, 0, 0, 0);
    for (int i = 0; i < NPIX; i++) begin
      tick(0, i == 12, 1, i == 0);
      compared++;
      if (got !== expv) begin
        mismatched++;
        $display("FAIL stop_pix%0d: got %h exp %h", i, got, expv);
      end
      if (frame_done === 1'b1) fdc++;
    end
    tick(0, 0, 0, 0);
    tick(0, 0, 1, 1);
    compared++;
    if (img_in_valid !== 1'b0 || busy !== 1'b0 || fdc != 1 || got !== expv) begin
      mismatched++;
      $display("FAIL stop_then_idle: got iv %b busy %b done %0d exp 0 0 1", img_in_valid, busy, fdc);
    end
  endtask
  task automatic test_mid_sof();
    int fdc;
    logic fc0;
    fdc = 0;
    continuous = 1'b0;
    tick(1, 0, 0, 0);
    for (int i = 0; i < 19; i++) tick(0, 0, 1, i == 0);
    fc0 = frame_code;
    tick(0, 0, 1, 1);
    compared++;
    if (err_sync !== 1'b1 || row !== 0 || col !== 0 || frame_code === fc0 || got !== expv) begin
      mismatched++;
      $display("FAIL midsof_restart: got err %b pos (%0d,%0d) code %b exp 1 (0,0) %b", err_sync, row, col, frame_code, !fc0);
    end
    for (int i = 0; i < NPIX - 1; i++) begin
      tick(0, 0, 1, 0);
      compared++;
      if (got !== expv) begin
        mismatched++;
        $display("FAIL midsof_pix%0d: got %h exp %h", i, got, expv);
      end
      if (frame_done === 1'b1) fdc++;
    end
    compared++;
    if (fdc != 1 || frame_done !== 1'b1) begin
      mismatched++;
      $display("FAIL midsof_done: got count %0d last %b exp 1 1", fdc, frame_done);
    end
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    compared++;
    if (err_sync !== 1'b0 || got !== expv) begin
      mismatched++;
      $display("FAIL midsof_clear: got err %b exp 0", err_sync);
    end
    tick(0, 1, 0, 0);
  endtask
  task automatic test_reset_mid();
    continuous = 1'b0;
    tick(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) tick(0, 0, 1, i == 0);
    in_valid = 1'b1;
    in_sof = 1'b0;
    do_reset();
    compared++;
    if (got !== 58'd0) begin
      mismatched++;
      $display("FAIL rstmid_zero: got %h exp 0", got);
    end
    tick(0, 0, 1, 1);
    compared++;
    if (img_in_valid !== 1'b0 || busy !== 1'b0 || got !== expv) begin
      mismatched++;
      $display("FAIL rstmid_nostart: got iv %b busy %b exp 0 0", img_in_valid, busy);
    end
  endtask
  task automatic test_random();
    bit st, sp, iv, sof;
    for (int k = 0; k < 600; k++) begin
      if (k % 50 == 0) continuous = 1'($urandom_range(0, 1));
      st = $urandom_range(0, 7) == 0;
      sp = $urandom_range(0, 40) == 0;
      iv = $urandom_range(0, 3) != 0;
      sof = iv && ((m_mode == 1 && $urandom_range(0, 1) == 1) || $urandom_range(0, 60) == 0);
      tick(st, sp, iv, sof);
      compared++;
      if (got !== expv) begin
        mismatched++;
        $display("FAIL random_cycle%0d: got %h exp %h", k, got, expv);
      end
    end
  endtask
  initial begin
    test_reset();
    test_single_frame();
    test_continuous_gaps();
    test_stop_mid();
    test_mid_sof();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
